input_spike_scanner: RTL

- Read-side sequencer for the input value memory. Sweeps addresses 0..INPUT_NEURON_NUM-1 once per timestep and reads each 8-bit input value.
- Integrate-and-fire rate encoding: adds each value to a per-neuron accumulator and emits a spike event (neuron address) whenever the accumulator reaches THRESH.
- Feeds the first SNN layer through a valid/ready event interface with backpressure.

---
 rtl/input_spike_scanner.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/input_spike_scanner.sv
// Input-layer rate encoder: sweeps the input value memory once per timestep and
// emits integrate-and-fire spike events. Optional spike counter: define SPIKE_COUNT_EN.
module input_spike_scanner #(
    parameter int INPUT_NEURON_NUM = 1023,
    parameter int ADDR_W           = 10,
    parameter int DATA_W           = 8,
    parameter int THRESH           = 256,
    parameter int STEP_W           = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_busy,
    output logic              spike_valid,
    input  logic              spike_ready,
    output logic [ADDR_W-1:0] spike_addr,
    output logic [STEP_W-1:0] spike_step,
    output logic              step_done,
    output logic              done
`ifdef SPIKE_COUNT_EN
    ,
    output logic [15:0]       spike_count
`endif
);

    localparam int ACC_W = DATA_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(INPUT_NEURON_NUM - 1);
    localparam logic [ACC_W-1:0]  THRESH_V  = ACC_W'(THRESH);

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, STEP_END, DONE} state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] num_steps_r;
    logic [STEP_W:0]   step_inc;
    logic              last_step;

    logic              s1_valid;
    logic              s1_first;
    logic [ADDR_W-1:0] s1_addr;
    logic [ACC_W-1:0]  s1_acc;

    logic              stalled_q;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] s1_data;
    logic [ACC_W-1:0]  base;
    logic [ACC_W-1:0]  sum;
    logic              fire;
    logic              stall;
    logic              drain_ok;

    logic [ACC_W-1:0]  acc_mem [INPUT_NEURON_NUM];

    // While frozen the memory keeps returning the next address, so the datum
    // belonging to stage 1 is parked in hold_data until the stall clears.
    assign s1_data  = stalled_q ? hold_data : mem_data_out;
    assign base     = s1_first ? '0 : s1_acc;
    assign sum      = base + {1'b0, s1_data};
    assign fire     = s1_valid && (sum >= THRESH_V);
    assign stall    = fire && spike_valid && !spike_ready;
    assign drain_ok = !stall && !fire && (!spike_valid || spike_ready);

    assign step_inc  = {1'b0, step} + {{STEP_W{1'b0}}, 1'b1};
    assign last_step = step_inc >= {1'b0, num_steps_r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = (num_steps == '0) ? DONE : SCAN;
            SCAN:     if (!stall && addr == LAST_ADDR) state_nx = DRAIN;
            DRAIN:    if (drain_ok) state_nx = STEP_END;
            STEP_END: state_nx = last_step ? DONE : SCAN;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_busy = (state != IDLE);
    end

    assign mem_addr_out = addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr        <= '0;
            step        <= '0;
            num_steps_r <= '0;
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_addr     <= '0;
            s1_acc      <= '0;
            stalled_q   <= 1'b0;
            hold_data   <= '0;
            spike_valid <= 1'b0;
            spike_addr  <= '0;
            spike_step  <= '0;
            step_done   <= 1'b0;
            done        <= 1'b0;
        end else begin
            stalled_q <= stall;
            if (stall) begin
                hold_data <= s1_data;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        num_steps_r <= num_steps;
                        step        <= '0;
                        addr        <= '0;
                    end
                end
                SCAN: begin
                    if (!stall) begin
                        s1_valid <= 1'b1;
                        s1_addr  <= addr;
                        s1_acc   <= acc_mem[addr];
                        s1_first <= (step == '0);
                        if (addr != LAST_ADDR) begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        s1_valid <= 1'b0;
                    end
                end
                STEP_END: begin
                    if (!last_step) begin
                        step <= step_inc[STEP_W-1:0];
                        addr <= '0;
                    end
                end
                default: ;
            endcase

            // Output register: a fresh spike may replace one accepted this cycle.
            if (!stall) begin
                if (fire) begin
                    spike_valid <= 1'b1;
                    spike_addr  <= s1_addr;
                    spike_step  <= step;
                end else if (spike_ready) begin
                    spike_valid <= 1'b0;
                end
            end

            step_done <= (state == STEP_END);
            done      <= (state == STEP_END && last_step) ||
                         (state == DONE && num_steps_r == '0);
        end
    end

    // Accumulators need no reset: step 0 ignores their old contents.
    always_ff @(posedge clk) begin
        if (s1_valid && !stall) begin
            acc_mem[s1_addr] <= fire ? (sum - THRESH_V) : sum;
        end
    end

`ifdef SPIKE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_count <= '0;
        end else if (state == IDLE && start) begin
            spike_count <= '0;
        end else if (spike_valid && spike_ready && spike_count != 16'hFFFF) begin
            spike_count <= spike_count + 16'd1;
        end
    end
`endif

endmodule
